// File: rtl/kernel_top_stream_join2.sv
// kernel_top_stream_join2
// Joins two valid/ready streams into {b, a} tuples and buffers them in a
// small registered FIFO. Both streams are consumed together or not at all,
// so the upstream delay-balanced path (A) and the direct path (B) stay
// aligned. The output side is decoded purely from registered state. That
// gives one cycle of latency and no combinational path from inputs to the
// output handshake.
module kernel_top_stream_join2 #(
    parameter int STREAMW = 32,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid_a,
    input  logic [STREAMW-1:0]       a,
    output logic                     iready_a,
    input  logic                     ivalid_b,
    input  logic [STREAMW-1:0]       b,
    output logic                     iready_b,
    output logic                     ovalid,
    output logic [2*STREAMW-1:0]     out,
    input  logic                     oready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              tuple_cnt
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int LVLW = PTRW + 1;
    localparam int TUPW = 2 * STREAMW;

    // Tuple storage is deliberately left unreset; the output is masked when empty.
    logic [TUPW-1:0] mem_q [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q,  level_d;
    logic [31:0]     cnt_q,    cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Occupancy flags and handshake decode, derived only from registered level.
    always_comb begin
        full     = (level_q == LVLW'(DEPTH));
        empty    = (level_q == '0);
        // Each side is only ready when its partner is valid, so neither stream
        // can be accepted alone. iready never depends on oready: a full FIFO
        // blocks the push even if a pop happens in the same cycle.
        iready_a = ivalid_b & ~full;
        iready_b = ivalid_a & ~full;
        push     = ivalid_a & ivalid_b & ~full;
        pop      = ~empty & oready;
        ovalid   = ~empty;
        out      = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Next-state arithmetic for pointers, level and delivered-tuple counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTRW'(1);
        rd_ptr_d = rd_ptr_q + PTRW'(1);
        cnt_d    = cnt_q + 32'd1;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state: reset wins over any push or pop presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
            level_q <= level_d;
        end
    end

    // Tuple write at the write pointer; suppressed during reset so a discarded push leaves no trace.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {b, a};
        end
    end

    assign level     = level_q;
    assign tuple_cnt = cnt_q;

endmodule

// File: tb/tb_kernel_top_stream_join2.sv
// Directed bench for kernel_top_stream_join2 with hand-computed expectations.
module tb_kernel_top_stream_join2;

    logic        clk;
    logic        rst;
    logic        ivalid_a;
    logic [31:0] a;
    logic        iready_a;
    logic        ivalid_b;
    logic [31:0] b;
    logic        iready_b;
    logic        ovalid;
    logic [63:0] out;
    logic        oready;
    logic [2:0]  level;
    logic [31:0] tuple_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    kernel_top_stream_join2 #(.STREAMW(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid_a  (ivalid_a),
        .a         (a),
        .iready_a  (iready_a),
        .ivalid_b  (ivalid_b),
        .b         (b),
        .iready_b  (iready_b),
        .ovalid    (ovalid),
        .out       (out),
        .oready    (oready),
        .level     (level),
        .tuple_cnt (tuple_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        ivalid_a = 1'b0;
        ivalid_b = 1'b0;
        a        = '0;
        b        = '0;
        oready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ovalid", ovalid, 0);
        check("rst_out", out, 0);
        check("rst_level", level, 0);
        check("rst_cnt", tuple_cnt, 0);
        check("rst_iready_a", iready_a, 0);
        check("rst_iready_b", iready_b, 0);
        ivalid_b = 1'b1;
        #1;
        check("rst_iready_a_b_valid", iready_a, 1);
        ivalid_b = 1'b0;
        rst = 1'b0;

        // Single tuple, one-cycle latency
        a = 32'h11; b = 32'h22; ivalid_a = 1'b1; ivalid_b = 1'b1; oready = 1'b1;
        #1;
        check("t1_iready_a", iready_a, 1);
        check("t1_iready_b", iready_b, 1);
        check("t1_no_comb_ovalid", ovalid, 0);
        tick();
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t1_ovalid", ovalid, 1);
        check("t1_out", out, 64'h00000022_00000011);
        check("t1_level", level, 1);
        tick();
        check("t1_cnt", tuple_cnt, 1);
        check("t1_level_after", level, 0);
        check("t1_ovalid_after", ovalid, 0);
        check("t1_out_masked", out, 0);

        // Only A valid: nothing consumed
        ivalid_a = 1'b1; a = 32'hA1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_iready_a", iready_a, 0);
            check("t2_iready_b", iready_b, 1);
            check("t2_ovalid", ovalid, 0);
            check("t2_level", level, 0);
            tick();
        end
        ivalid_b = 1'b1; b = 32'h5;
        #1;
        check("t2_iready_a_join", iready_a, 1);
        tick();
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t2_ovalid_join", ovalid, 1);
        check("t2_out", out, 64'h00000005_000000A1);
        tick();
        check("t2_single_tuple", ovalid, 0);
        check("t2_cnt", tuple_cnt, 2);

        // Fill with back-pressure, then drain in order
        oready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a = i; b = i; ivalid_a = 1'b1; ivalid_b = 1'b1;
            tick();
        end
        a = 32'h9; b = 32'h9;
        #1;
        check("t3_level_full", level, 4);
        check("t3_iready_a_full", iready_a, 0);
        check("t3_iready_b_full", iready_b, 0);
        check("t3_ovalid", ovalid, 1);
        check("t3_out_head", out, 64'h00000001_00000001);
        tick();
        check("t3_level_hold", level, 4);
        check("t3_out_stable", out, 64'h00000001_00000001);
        oready = 1'b1;
        #1;
        check("t3_full_blocks_push", iready_a, 0);
        tick();
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t3_level_pop_no_push", level, 3);
        check("t3_out2", out, 64'h00000002_00000002);
        tick();
        check("t3_out3", out, 64'h00000003_00000003);
        tick();
        check("t3_out4", out, 64'h00000004_00000004);
        tick();
        check("t3_level_drained", level, 0);
        check("t3_ovalid_drained", ovalid, 0);
        check("t3_cnt", tuple_cnt, 6);

        // Streaming at one tuple per cycle across pointer wrap
        oready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 32'h100 + i; b = 32'h200 + i; ivalid_a = 1'b1; ivalid_b = 1'b1;
            if (i > 0) begin
                check("t4_out", out, {32'h200 + 32'(i - 1), 32'h100 + 32'(i - 1)});
                check("t4_level", level, 1);
            end
            tick();
        end
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t4_out_last", out, {32'h213, 32'h113});
        check("t4_level_last", level, 1);
        tick();
        check("t4_level_end", level, 0);
        check("t4_cnt", tuple_cnt, 26);

        // Mid-operation reset discards stored tuples and same-cycle traffic
        oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'h30 + i; b = 32'h30 + i; ivalid_a = 1'b1; ivalid_b = 1'b1;
            tick();
        end
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t5_level_pre", level, 3);
        check("t5_ovalid_pre", ovalid, 1);
        rst = 1'b1; a = 32'hEE; b = 32'hEE; ivalid_a = 1'b1; ivalid_b = 1'b1; oready = 1'b1;
        tick();
        rst = 1'b0; ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t5_ovalid", ovalid, 0);
        check("t5_out", out, 0);
        check("t5_level", level, 0);
        check("t5_cnt", tuple_cnt, 0);
        a = 32'h77; b = 32'h88; ivalid_a = 1'b1; ivalid_b = 1'b1;
        tick();
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t5_out_after", out, 64'h00000088_00000077);
        tick();
        check("t5_cnt_after", tuple_cnt, 1);
        check("t5_level_after", level, 0);

        // Delivered-tuple counter wrap
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        check("t6_cnt_preload", tuple_cnt, 32'hFFFF_FFFE);
        oready = 1'b1;
        a = 32'h1; b = 32'h1; ivalid_a = 1'b1; ivalid_b = 1'b1;
        tick();
        a = 32'h2; b = 32'h2;
        check("t6_cnt_hold", tuple_cnt, 32'hFFFF_FFFE);
        check("t6_out1", out, 64'h00000001_00000001);
        tick();
        ivalid_a = 1'b0; ivalid_b = 1'b0;
        check("t6_cnt_max", tuple_cnt, 32'hFFFF_FFFF);
        check("t6_out2", out, 64'h00000002_00000002);
        tick();
        check("t6_cnt_wrap", tuple_cnt, 32'h0000_0000);
        check("t6_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_top_stream_join2.md
KERNEL_TOP_STREAM_JOIN2 -- requirements
Module: kernel_top_stream_join2

Interface
REQ-001 Parameter STREAMW, default 32, width of each input data stream.
REQ-002 Parameter DEPTH, default 4, output FIFO depth in tuples; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ivalid_a  input  1  stream A valid (delay-balanced path from the upstream local buffer).
REQ-006 a  input  STREAMW  stream A data.
REQ-007 iready_a  output  1  stream A ready.
REQ-008 ivalid_b  input  1  stream B valid (direct path).
REQ-009 b  input  STREAMW  stream B data.
REQ-010 iready_b  output  1  stream B ready.
REQ-011 ovalid  output  1  joined tuple valid.
REQ-012 out  output  2*STREAMW  joined tuple {b, a}, with a in the low STREAMW bits.
REQ-013 oready  input  1  downstream ready.
REQ-014 level  output  clog2(DEPTH)+1  current FIFO occupancy, range 0..DEPTH.
REQ-015 tuple_cnt  output  32  count of tuples delivered downstream.

Function
REQ-016 full SHALL be (level == DEPTH) and empty SHALL be (level == 0), both decoded from registered state only.
REQ-017 iready_a SHALL equal ivalid_b & !full, and iready_b SHALL equal ivalid_a & !full, so that neither stream is consumed alone.
REQ-018 push SHALL be ivalid_a & ivalid_b & !full; on push, {b, a} SHALL be written at the write pointer and the write pointer SHALL advance modulo DEPTH.
REQ-019 ovalid SHALL equal !empty, and out SHALL present the head entry whenever ovalid is 1.
REQ-020 out SHALL be all zeros whenever empty.
REQ-021 pop SHALL be ovalid & oready; on pop, the read pointer SHALL advance modulo DEPTH and tuple_cnt SHALL increment, wrapping from 0xFFFFFFFF to 0.
REQ-022 Latency: a tuple pushed at edge N SHALL appear with ovalid=1 in the cycle after edge N (one cycle), with no combinational path from inputs to ovalid/out.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; push only SHALL increment level; pop only SHALL decrement it.
REQ-024 When full, push SHALL be blocked even if oready=1 in the same cycle (no pass-through), so that iready has no combinational dependence on oready.
REQ-025 While ovalid=1 and oready=0, ovalid and out SHALL remain stable until the pop occurs.
REQ-026 Tuples SHALL be delivered in push order, with no loss or duplication across pointer wrap.
REQ-027 If only one input is valid, no state SHALL change for that input and its data SHALL NOT be consumed.

Reset
REQ-028 While rst=1 at an edge, the pointers, level and tuple_cnt SHALL be cleared to 0, giving ovalid=0, out=0, iready_a=iready_b=0 unless the other input is valid (level=0 so not full).
REQ-029 rst asserted mid-operation SHALL discard all stored tuples, and pushes or pops presented in that same cycle SHALL be ignored.
REQ-030 FIFO storage contents SHALL NOT need reset, because out is masked to 0 when empty.

Verification
REQ-031 Reset, then a=0x11, b=0x22 both valid for one cycle with oready=1 -> next cycle ovalid=1, out=0x00000022_00000011; after the pop, tuple_cnt=1 and level=0.
REQ-032 ivalid_a=1 only for 5 cycles, then ivalid_b=1 with b=0x5 -> iready_a=0 throughout the A-only cycles; exactly one tuple {0x5, a} is produced.
REQ-033 oready=0 while 4 tuples are pushed (values 1..4) -> level=4, iready_a=iready_b=0, ovalid held with out={1,1}; then oready=1 for 4 cycles -> tuples 1..4 in order, level returns to 0.
REQ-034 Both inputs valid and oready=1 continuously for 20 cycles with incrementing data -> throughput of 1 tuple per cycle after 1-cycle latency, level steady at 1, ordering correct across the pointer wrap.
REQ-035 rst pulsed with level=3 -> next cycle ovalid=0, out=0, level=0, tuple_cnt=0; subsequent traffic works normally.
REQ-036 tuple_cnt forced near wrap (0xFFFFFFFE start via 2 pops after preload, or by force) -> it wraps to 0x00000000 on the second pop.
